// File: rtl/spi_master_ipif.sv
// ============================================================================
//  Module   : spi_master_ipif
//  Purpose  : Parametrised SPI master behind an IPIF-style register bus.
//             One word is shifted per TXDATA write; all four CPOL/CPHA modes,
//             MSB/LSB-first ordering, programmable SCK divider, CS hold
//             between words and sticky WR_ERR / OVERRUN status.
//  Ports    : bus2ip_clk/rst         - clock, async active-high reset
//             bus2ip_data/wrce/rdce  - register write data and one-hot enables
//             ip2bus_data/wrack/rdack- registered read data and acknowledges
//             SPI_SCK/MOSI/MISO/CSn  - serial interface, CSn active low
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_master_ipif #(
  parameter int DATA_W = 8,
  parameter int NCS    = 4,
  parameter int DIV_W  = 8
) (
  input  logic              bus2ip_clk,
  input  logic              rst,
  input  logic [31:0]       bus2ip_data,
  input  logic [3:0]        bus2ip_wrce,
  input  logic [3:0]        bus2ip_rdce,
  output logic [31:0]       ip2bus_data,
  output logic              ip2bus_wrack,
  output logic              ip2bus_rdack,
  output logic              SPI_SCK,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO,
  output logic [NCS-1:0]    SPI_CSn
);

  localparam int CSW = (NCS > 1) ? $clog2(NCS) : 1;
  localparam int HPW = $clog2(2 * DATA_W);
  localparam logic [HPW-1:0] HP_LAST = HPW'(2 * DATA_W - 1);
  localparam logic [HPW-1:0] HP_PEN  = HPW'(2 * DATA_W - 2);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL} state_t;

  state_t              state_q, state_d;
  logic                cpha_q, cpol_q, lsb_q, hold_q;
  logic [CSW-1:0]      cs_sel_q;
  logic [DIV_W-1:0]    div_q, cnt_q;
  logic [HPW-1:0]      hp_q;          // half-period index inside SHIFT
  logic [DATA_W-1:0]   tx_q, rx_q, rxdata_q;
  logic                mosi_q, cs_act_q;
  logic                rx_valid_q, overrun_q, wr_err_q;
  logic [31:0]         rd_data_q;
  logic                wrack_q, rdack_q;

  logic                busy, start, tick, hp_last, done;
  logic                lead_edge, trail_edge, do_sample, do_shift;
  logic [DATA_W-1:0]   tx_word;
  logic [CSW-1:0]      new_sel;
  logic [31:0]         rd_mux;
  logic                unused_bits;

  assign unused_bits = ^bus2ip_data;
  assign tx_word     = bus2ip_data[DATA_W-1:0];
  assign new_sel     = bus2ip_data[8 +: CSW];

  always_comb begin
    busy    = (state_q != S_IDLE);
    start   = bus2ip_wrce[2] && !busy;
    tick    = (cnt_q == div_q);
    hp_last = (hp_q == HP_LAST);
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LEAD;
      S_LEAD:  if (tick)  state_d = S_SHIFT;
      S_SHIFT: if (tick && hp_last) begin
        if (hold_q) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end else begin
          state_d = S_TRAIL;
        end
      end
      S_TRAIL: if (tick) begin
        state_d = S_IDLE;
        done    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // SCK edges: leading edges enter even half-periods, trailing edges odd
    // ones. The end of the last half-period is not an edge, SCK is already
    // back at CPOL there.
    lead_edge  = ((state_q == S_LEAD) && tick) ||
                 ((state_q == S_SHIFT) && tick && !hp_last && hp_q[0]);
    trail_edge = (state_q == S_SHIFT) && tick && !hp_last && !hp_q[0];
    do_sample  = cpha_q ? trail_edge : lead_edge;
    // In CPHA=0 the first bit is preloaded, so the final trailing edge would
    // shift past the word; skipping it keeps MOSI on the last bit.
    do_shift   = cpha_q ? lead_edge : (trail_edge && (hp_q != HP_PEN));
  end

  always_comb begin
    rd_mux = 32'd0;
    if (bus2ip_rdce[0])
      rd_mux = {{(24 - CSW){1'b0}}, cs_sel_q, 4'b0000, hold_q, lsb_q, cpol_q, cpha_q};
    else if (bus2ip_rdce[1])
      rd_mux = 32'(div_q);
    else if (bus2ip_rdce[2])
      rd_mux = {28'd0, wr_err_q, overrun_q, rx_valid_q, busy};
    else if (bus2ip_rdce[3])
      rd_mux = 32'(rxdata_q);
  end

  always_ff @(posedge bus2ip_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cpha_q     <= 1'b0;
      cpol_q     <= 1'b0;
      lsb_q      <= 1'b0;
      hold_q     <= 1'b0;
      cs_sel_q   <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      hp_q       <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rxdata_q   <= '0;
      mosi_q     <= 1'b0;
      cs_act_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_data_q  <= '0;
      wrack_q    <= 1'b0;
      rdack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wrack_q   <= |bus2ip_wrce;
      rdack_q   <= |bus2ip_rdce;
      rd_data_q <= rd_mux;

      if (bus2ip_wrce[0] && !busy) begin
        cpha_q   <= bus2ip_data[0];
        cpol_q   <= bus2ip_data[1];
        lsb_q    <= bus2ip_data[2];
        hold_q   <= bus2ip_data[3];
        cs_sel_q <= new_sel;
        // A held CS is released when hold is dropped or the target changes.
        if (!bus2ip_data[3] || (new_sel != cs_sel_q))
          cs_act_q <= 1'b0;
      end
      if (bus2ip_wrce[1] && !busy)
        div_q <= bus2ip_data[DIV_W-1:0];

      if (start) begin
        cs_act_q <= 1'b1;
        cnt_q    <= '0;
        hp_q     <= '0;
        if (!cpha_q) begin
          mosi_q <= lsb_q ? tx_word[0] : tx_word[DATA_W-1];
          tx_q   <= lsb_q ? (tx_word >> 1) : (tx_word << 1);
        end else begin
          tx_q   <= tx_word;
        end
      end else if (busy) begin
        cnt_q <= tick ? '0 : cnt_q + 1'b1;
        if ((state_q == S_SHIFT) && tick)
          hp_q <= hp_q + 1'b1;
        if (do_shift) begin
          mosi_q <= lsb_q ? tx_q[0] : tx_q[DATA_W-1];
          tx_q   <= lsb_q ? (tx_q >> 1) : (tx_q << 1);
        end
        if (do_sample)
          rx_q <= lsb_q ? {SPI_MISO, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], SPI_MISO};
        if ((state_q == S_TRAIL) && tick)
          cs_act_q <= 1'b0;
      end

      // Clears first, sets last: a simultaneous set always wins.
      if (bus2ip_rdce[3])
        rx_valid_q <= 1'b0;
      if (bus2ip_wrce[3] && bus2ip_data[2])
        overrun_q <= 1'b0;
      if (bus2ip_wrce[3] && bus2ip_data[3])
        wr_err_q <= 1'b0;
      if (busy && (|bus2ip_wrce[2:0]))
        wr_err_q <= 1'b1;
      if (done) begin
        rxdata_q   <= rx_q;
        rx_valid_q <= 1'b1;
        if (rx_valid_q && !bus2ip_rdce[3])
          overrun_q <= 1'b1;
      end
    end
  end

  assign SPI_SCK      = (state_q == S_SHIFT) ? (cpol_q ^ ~hp_q[0]) : cpol_q;
  assign SPI_MOSI     = mosi_q;
  assign ip2bus_data  = rd_data_q;
  assign ip2bus_wrack = wrack_q;
  assign ip2bus_rdack = rdack_q;

  for (genvar i = 0; i < NCS; i++) begin : g_cs
    assign SPI_CSn[i] = ~(cs_act_q && (cs_sel_q == CSW'(i)));
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_master_ipif.sv
// ============================================================================
//  Module   : tb_spi_master_ipif
//  Purpose  : Directed self-checking bench for spi_master_ipif (DATA_W=8,
//             NCS=4, DIV_W=8) with hand-computed expected values.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_master_ipif;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus2ip_data;
  logic [3:0]  bus2ip_wrce, bus2ip_rdce;
  logic [31:0] ip2bus_data;
  logic        ip2bus_wrack, ip2bus_rdack;
  logic        sck, mosi, miso;
  logic [3:0]  csn;
  logic        loopback, miso_val;

  int n_checks = 0;
  int n_pass   = 0;

  assign miso = loopback ? mosi : miso_val;

  always #5 clk = ~clk;

  spi_master_ipif #(.DATA_W(8), .NCS(4), .DIV_W(8)) dut (
    .bus2ip_clk   (clk),
    .rst          (rst),
    .bus2ip_data  (bus2ip_data),
    .bus2ip_wrce  (bus2ip_wrce),
    .bus2ip_rdce  (bus2ip_rdce),
    .ip2bus_data  (ip2bus_data),
    .ip2bus_wrack (ip2bus_wrack),
    .ip2bus_rdack (ip2bus_rdack),
    .SPI_SCK      (sck),
    .SPI_MOSI     (mosi),
    .SPI_MISO     (miso),
    .SPI_CSn      (csn)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(posedge clk); #1;
    bus2ip_data = d;
    bus2ip_wrce = 4'(1 << a);
    @(posedge clk); #1;
    bus2ip_wrce = 4'b0;
    check("wrack", {31'd0, ip2bus_wrack}, 32'd1);
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    @(posedge clk); #1;
    bus2ip_rdce = 4'(1 << a);
    @(posedge clk); #1;
    bus2ip_rdce = 4'b0;
    d = ip2bus_data;
  endtask

  task automatic rd_chk(input string tag, input int a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  // Follows a transfer while any CSn is low: cycle count, cycles whose CSn
  // differs from cs_exp, MOSI bits captured on each SCK rising edge, and
  // number of cycles with SCK high.
  task automatic watch(input logic [3:0] cs_exp, output int cyc, output int bad,
                       output logic [31:0] bits, output int hi);
    logic prev;
    cyc = 0; bad = 0; bits = '0; hi = 0;
    prev = sck;
    while (csn != 4'hF && cyc < 2000) begin
      cyc++;
      if (csn != cs_exp) bad++;
      if (sck) hi++;
      if (sck && !prev) bits = {bits[30:0], mosi};
      prev = sck;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bad, hi;
    logic [31:0] bits;
    rst = 1'b1; bus2ip_data = '0; bus2ip_wrce = '0; bus2ip_rdce = '0;
    loopback = 1'b1; miso_val = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_csn",  {28'd0, csn}, 32'hF);
    check("rst_sck",  {31'd0, sck}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_ack",  {30'd0, ip2bus_wrack, ip2bus_rdack}, 32'd0);
    check("rst_data", ip2bus_data, 32'd0);
    rd_chk("rst_status", 2, 32'h0);

    // Mode 0, DIV=0, CS_SEL=1, 0xA5 loopback
    wr(0, 32'h100);
    wr(1, 32'h0);
    wr(2, 32'hA5);
    watch(4'b1101, cyc, bad, bits, hi);
    check("m0_cycles", cyc, 18);
    check("m0_csn_bad", bad, 0);
    check("m0_mosi", bits, 32'hA5);
    check("m0_sck_hi", hi, 8);
    rd_chk("m0_status", 2, 32'h2);
    rd_chk("m0_rxdata", 3, 32'hA5);
    rd_chk("m0_status2", 2, 32'h0);

    // Mode 3, LSB first, DIV=3, 0x3C, MISO tied 1
    loopback = 1'b0; miso_val = 1'b1;
    wr(0, 32'h7);
    wr(1, 32'h3);
    rd_chk("m3_div", 1, 32'h3);
    rd_chk("m3_ctrl", 0, 32'h7);
    check("m3_sck_idle", {31'd0, sck}, 32'd1);
    wr(2, 32'h3C);
    watch(4'b1110, cyc, bad, bits, hi);
    check("m3_cycles", cyc, 72);
    check("m3_mosi", bits, 32'h3C);
    check("m3_sck_hi", hi, 40);
    check("m3_sck_end", {31'd0, sck}, 32'd1);
    rd_chk("m3_rxdata", 3, 32'hFF);

    // TXDATA write while busy
    loopback = 1'b1;
    wr(0, 32'h0);
    wr(1, 32'h0);
    wr(2, 32'h5A);
    wr(2, 32'hFF);
    watch(4'b1110, cyc, bad, bits, hi);
    rd_chk("werr_status", 2, 32'hA);
    rd_chk("werr_rxdata", 3, 32'h5A);
    wr(3, 32'h8);
    rd_chk("werr_clear", 2, 32'h0);

    // Two words without reading RXDATA
    wr(2, 32'h11);
    watch(4'b1110, cyc, bad, bits, hi);
    wr(2, 32'h22);
    watch(4'b1110, cyc, bad, bits, hi);
    rd_chk("ovr_status", 2, 32'h6);
    rd_chk("ovr_rxdata", 3, 32'h22);
    wr(3, 32'h4);
    rd_chk("ovr_clear", 2, 32'h0);

    // CS_HOLD, two back-to-back words
    wr(0, 32'h8);
    wr(2, 32'h81);
    repeat (17) begin @(posedge clk); #1; end
    check("hold_csn1", {28'd0, csn}, 32'hE);
    rd_chk("hold_status1", 2, 32'h2);
    wr(2, 32'h7E);
    bad = 0;
    repeat (17) begin
      if (csn != 4'b1110) bad++;
      @(posedge clk); #1;
    end
    check("hold_csn_bad", bad, 0);
    rd_chk("hold_rxdata", 3, 32'h7E);
    rd_chk("hold_status2", 2, 32'h4);
    check("hold_csn2", {28'd0, csn}, 32'hE);
    wr(0, 32'h0);
    check("hold_release", {28'd0, csn}, 32'hF);
    wr(3, 32'h4);

    // Reset mid-transfer (CPOL=1 so SCK dropping to 0 is visible)
    wr(0, 32'h2);
    wr(1, 32'h3);
    wr(2, 32'hC3);
    repeat (36) begin @(posedge clk); #1; end
    check("mid_sck_busy_csn", {28'd0, csn}, 32'hE);
    rst = 1'b1;
    #1;
    check("mid_rst_csn", {28'd0, csn}, 32'hF);
    check("mid_rst_sck", {31'd0, sck}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd_chk("mid_rst_status", 2, 32'h0);
    wr(2, 32'h96);
    watch(4'b1110, cyc, bad, bits, hi);
    check("post_cycles", cyc, 18);
    check("post_mosi", bits, 32'h96);
    rd_chk("post_rxdata", 3, 32'h96);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_master_ipif.md
# spi_master_ipif

Parametrised SPI master engine that sits behind the team's AXI-Lite address-management front end on the IPIF-style bus (bus2ip/ip2bus). It is the successor to the fixed-format SPI IP. It adds configurable word width, a chip-select count, all four CPOL/CPHA modes, MSB/LSB-first ordering, a programmable SCK divider, CS hold between words, and sticky error/overrun status. One word is transferred per TXDATA write, and received data is held in RXDATA.

## Interface
- DATA_W, 8: SPI word width in bits; legal range 4..32.
- NCS, 4: number of chip-select outputs; legal range 1..16. CSW = max(1, ceil(log2(NCS))).
- DIV_W, 8: width of the SCK divider register.
- bus2ip_clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- bus2ip_data  in  32  write data.
- bus2ip_wrce  in  4  one-hot write enable; bit i selects register i.
- bus2ip_rdce  in  4  one-hot read enable; bit i selects register i.
- ip2bus_data  out  32  read data; zero whenever ip2bus_rdack = 0.
- ip2bus_wrack  out  1  one-cycle write acknowledge.
- ip2bus_rdack  out  1  one-cycle read acknowledge.
- SPI_SCK  out  1  serial clock.
- SPI_MOSI  out  1  serial data out.
- SPI_MISO  in  1  serial data in.
- SPI_CSn  out  NCS  active-low chip selects.

## Operation
- Registers:
  - reg0 CTRL (RW): [0] CPHA, [1] CPOL, [2] LSB_FIRST, [3] CS_HOLD, [8+:CSW] CS_SEL.
  - reg1 DIV (RW): [DIV_W-1:0]; SCK half-period = DIV+1 clocks.
  - reg2 (write): TXDATA[DATA_W-1:0] starts a transfer.
  - reg2 (read): STATUS = {28'b0, WR_ERR, OVERRUN, RX_VALID, BUSY}.
  - reg3 (read): RXDATA, zero-extended; clears RX_VALID.
  - reg3 (write): write-1-to-clear of OVERRUN (bit 2) and WR_ERR (bit 3).
- Writes to CTRL, DIV or TXDATA while BUSY=1 are discarded, set WR_ERR, and are still acknowledged.
- FSM states are IDLE, LEAD, SHIFT and TRAIL.
  - IDLE -> LEAD on a TXDATA write: shift register loaded, BUSY set, CSn[CS_SEL] driven low.
  - LEAD lasts one half-period, then goes to SHIFT.
  - SHIFT produces 2*DATA_W SCK edges, one every half-period.
  - SHIFT -> TRAIL if CS_HOLD=0, else -> IDLE with CS still asserted.
  - TRAIL lasts one half-period, deasserts CS, then goes to IDLE.
- Bit timing by mode:
  - CPHA=0: the first bit is on MOSI from LEAD entry. Sample on each leading edge, shift on each trailing edge.
  - CPHA=1: shift on each leading edge, sample on each trailing edge.
  - The leading edge is SCK leaving CPOL.
- Bit order is MSB first unless LSB_FIRST=1.
- SCK idles at CTRL.CPOL in IDLE, LEAD and TRAIL.
- MOSI holds its last driven bit when idle.
- On completion, RXDATA is loaded and RX_VALID set. If RX_VALID was already 1, RXDATA is still overwritten and OVERRUN is set.
- CS_HOLD=1 keeps the selected CSn low in IDLE until either a CTRL write with CS_HOLD=0 (CSn released the next cycle) or a CS_SEL change.
- If CS_SEL >= NCS, the transfer runs normally and all CSn stay high.

## Timing
- Reset values: SPI_CSn all 1s, SPI_SCK 0, SPI_MOSI 0, ip2bus_* 0, all registers and flags 0, FSM in IDLE.
- Reset asserted mid-transfer aborts it immediately. The partially received word is lost.
- Acks are registered: a wrce/rdce pulse in cycle n gives an ack in cycle n+1 (1-cycle latency).
  - Read data is valid with the ack.
  - rdce/wrce held high for several cycles produces one ack per cycle.
- A TXDATA write accepted in cycle n gives BUSY=1 and CSn low from cycle n+1.
- Transfer duration (BUSY high) is (2*DATA_W + 2)*(DIV+1) clocks with CS_HOLD=0, and (2*DATA_W + 1)*(DIV+1) clocks with CS_HOLD=1.
- RX_VALID rises in the same cycle BUSY falls.
- Simultaneous completion and an RXDATA read: the new word wins, RX_VALID stays 1 and OVERRUN is not set.
- Simultaneous completion and an OVERRUN clear: the set wins.
- MISO is sampled by the clock edge that generates the sample SCK edge.

## Test plan
- Mode 0, DATA_W=8, DIV=0, CS_SEL=1, TXDATA=0xA5, MISO loopback:
  - MOSI is 1,0,1,0,0,1,0,1 and CSn=4'b1101 for 18 cycles.
  - STATUS then reads 0x2 and RXDATA reads 0xA5, after which STATUS reads 0x0.
- Mode 3, LSB_FIRST=1, DIV=3, TXDATA=0x3C, MISO tied 1:
  - SCK idles 1 with a 4-clock half-period; MOSI sends 0,0,1,1,1,1,0,0.
  - RXDATA=0xFF and BUSY is high for 72 cycles.
- TXDATA write while BUSY:
  - The write is ignored, wrack is still pulsed, STATUS bit 3 = 1, and the original word completes.
  - A write of 0x8 to reg3 clears bit 3.
- Two transfers without reading RXDATA (0x11 then 0x22): RXDATA=0x22 and STATUS=0x6.
- CS_HOLD=1, two back-to-back words: CSn stays low across both, then a CTRL write with CS_HOLD=0 raises CSn one cycle later.
- Assert rst halfway through a transfer: CSn=all 1s, SCK=0, BUSY=0 immediately; a new transfer after release completes correctly.
